alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle integer ALU; successor to the combinational ALU in the execute stage.
//  - Keeps the 16-bit one-hot op select: ALU, RV32M and AMO operations.
//  - Adds true signed semantics and a valid/ready handshake on both sides.
//  - Pipelined multiply, iterative radix-2 divide, RISC-V divide-by-zero/overflow rules.
//  - One operation in flight; sits between the decode/issue logic and writeback.
// PARAMETERS
//  XLEN      32  operand width (>=8, power of 2)
//  MUL_LAT   2   multiply latency in cycles from accept to out_valid (1..4)
//  SHW       $clog2(XLEN)  shift-amount width (derived localparam, not overridable)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        operation request
//  in_ready     out  1        ALU can accept (high only in IDLE)
//  in1          in   XLEN     source operand 1
//  in2          in   XLEN     source operand 2
//  op           in   16       one-hot op select; bit order unchanged from the combinational ALU:
//                             0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu,
//                             10 mul, 11 div, 12 rem, 13 swap, 14 max, 15 min
//  op_signed    in   1        signed interpretation for mul/div/rem/max/min
//  out_valid    out  1        result available
//  out_ready    in   1        consumer accepts result
//  result       out  2*XLEN   result; non-mul ops zero-extended from XLEN
//  err          out  1        illegal op (zero or multi-hot op, or disabled M op)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, err=0; any in-flight op is dropped.
//  - Accept: in_valid & in_ready at a rising edge. Operands, op and op_signed are latched; inputs are don't-care afterwards.
//  - FSM states:
//    - IDLE: on accept, single-cycle/illegal ops go to DONE, mul goes to MUL, div/rem go to DIV.
//    - MUL: counts MUL_LAT-1 cycles, then DONE.
//    - DIV: runs XLEN restoring iterations, one quotient bit per cycle, then a sign-fix cycle, then DONE.
//    - DONE: out_valid=1; result/err stable until out_valid & out_ready, then IDLE.
//  - Latency, accept edge to out_valid high:
//    - 1 cycle for single-cycle and illegal ops.
//    - MUL_LAT cycles for mul.
//    - XLEN+2 cycles for div/rem.
//  - Throughput is one op per (latency+1) cycles minimum. The DONE->IDLE transition returns in_ready next cycle (no same-cycle re-accept).
//  - Arithmetic:
//    - add/sub/logic wrap modulo 2^XLEN.
//    - Shifts use in2[SHW-1:0]. sra is arithmetic, srl is logical.
//    - slt is signed, sltu is unsigned; each gives 0/1.
//    - swap returns in2.
//    - max/min compare signed if op_signed, else unsigned.
//    - mul gives the full 2*XLEN product, signed x signed if op_signed, else unsigned.
//    - div/rem truncate toward zero.
//  - Divide boundaries:
//    - in2==0: div returns all-ones (XLEN bits), rem returns in1. DIV still takes the full XLEN+2 cycles.
//    - Signed overflow (in1 = -2^(XLEN-1), in2 = -1): div returns in1, rem returns 0.
//  - Illegal op: result=0, err=1. err is 0 for every legal op.
//  - Reset mid-MUL/DIV aborts the op; no out_valid is produced for it.
// CONFIGURATION
//  ALU_MULDIV_EN defined: mul/div/rem implemented as above.
//  ALU_MULDIV_EN undefined:
//    - op bits 10-12 are treated as illegal (1-cycle, result=0, err=1).
//    - MUL/DIV states and datapaths are not synthesised.
// TESTING
//  - Reset: hold rst_n=0 mid-DIV for 1 cycle -> out_valid=0, in_ready=1. No stale result afterwards.
//  - add 0xFFFFFFFF+1 (XLEN=32) -> result=0 one cycle after accept.
//  - sra 0x80000000 by 4 -> 0xF8000000. max signed(-1, 1) -> 1. max unsigned(-1, 1) -> 0xFFFFFFFF.
//  - mul signed 0xFFFFFFFF x 2 -> 0xFFFFFFFF_FFFFFFFE. out_valid exactly MUL_LAT cycles after accept.
//  - div signed -7/2 -> 0xFFFFFFFD, rem -> 0xFFFFFFFF.
//    div 5/0 -> 0xFFFFFFFF. rem 5/0 -> 5.
//    div 0x80000000/-1 -> 0x80000000. Each at XLEN+2 cycles.
//  - Backpressure: out_ready=0 for 5 cycles -> result/out_valid held, in_ready=0.
//    op=0x0003 -> err=1, result=0.

Source files
------------

// File: rtl/alu_mc_if.sv
// Issue-side request channel and writeback-side response channel of the multi-cycle ALU.
// The master modport belongs to decode/issue and writeback; the slave modport belongs to the ALU.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in1;
  logic [XLEN-1:0]   in2;
  logic [15:0]       op;
  logic              op_signed;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] result;
  logic              err;

  modport master (
    output in_valid, in1, in2, op, op_signed, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, in1, in2, op, op_signed, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with one operation in flight: single-cycle ALU ops, pipelined mul, radix-2 div/rem.
// Define ALU_MULDIV_EN to build mul/div/rem; without it op bits 10-12 decode as illegal.
module alu_mc #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_AND  = 4;
  localparam int OP_SLL  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_SLT  = 8;
  localparam int OP_SLTU = 9;
  localparam int OP_MUL  = 10;
  localparam int OP_DIV  = 11;
  localparam int OP_REM  = 12;
  localparam int OP_SWAP = 13;
  localparam int OP_MAX  = 14;
  localparam int OP_MIN  = 15;

  if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0 || MUL_LAT < 1 || MUL_LAT > 4) begin : g_bad_param
    $error("alu_mc: XLEN must be a power of 2 >= 8 and MUL_LAT must be 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ALU_MULDIV_EN
    S_MUL,
    S_DIV,
`endif
    S_DONE
  } state_t;

  state_t state, state_d;

  logic              accept;
  logic              legal;
  logic [XLEN-1:0]   alu_y;
  logic [2*XLEN-1:0] acc_res;
  logic [2*XLEN-1:0] result_q;
  logic              err_q;
  logic              lt_s, lt_u, lt_sel;

  assign accept = bus.in_valid && (state == S_IDLE);

`ifdef ALU_MULDIV_EN
  localparam int                CNTW     = $clog2(XLEN + 1);
  localparam logic [CNTW-1:0]   MUL_LAST = CNTW'(MUL_LAT - 2);
  localparam logic [CNTW-1:0]   DIV_LAST = CNTW'(XLEN);

  logic              is_mul, is_divrem;
  logic [XLEN-1:0]   a_q, b_q;
  logic              sgn_q, rem_q, a_neg, b_neg;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   div_q, div_r, div_b;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   q_fix, r_fix;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic              mul_s;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_y;

  assign legal     = $onehot(bus.op);
  assign is_mul    = bus.op[OP_MUL];
  assign is_divrem = bus.op[OP_DIV] | bus.op[OP_REM];

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
  endfunction
`else
  assign legal = $onehot(bus.op) && !bus.op[OP_MUL] && !bus.op[OP_DIV] && !bus.op[OP_REM];
`endif

  // Single-cycle ops always see the live bus operands: they complete on the accept edge.
  assign lt_s   = $signed(bus.in1) < $signed(bus.in2);
  assign lt_u   = bus.in1 < bus.in2;
  assign lt_sel = bus.op_signed ? lt_s : lt_u;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_y = '0;
    case (1'b1)
      bus.op[OP_ADD]:  alu_y = bus.in1 + bus.in2;
      bus.op[OP_SUB]:  alu_y = bus.in1 - bus.in2;
      bus.op[OP_XOR]:  alu_y = bus.in1 ^ bus.in2;
      bus.op[OP_OR]:   alu_y = bus.in1 | bus.in2;
      bus.op[OP_AND]:  alu_y = bus.in1 & bus.in2;
      bus.op[OP_SLL]:  alu_y = bus.in1 << bus.in2[SHW-1:0];
      bus.op[OP_SRL]:  alu_y = bus.in1 >> bus.in2[SHW-1:0];
      bus.op[OP_SRA]:  alu_y = $signed(bus.in1) >>> bus.in2[SHW-1:0];
      bus.op[OP_SLT]:  alu_y = XLEN'(lt_s);
      bus.op[OP_SLTU]: alu_y = XLEN'(lt_u);
      bus.op[OP_SWAP]: alu_y = bus.in2;
      bus.op[OP_MAX]:  alu_y = lt_sel ? bus.in2 : bus.in1;
      bus.op[OP_MIN]:  alu_y = lt_sel ? bus.in1 : bus.in2;
      default:         alu_y = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // MUL_LAT==1 multiplies the live operands; longer latencies use the latched copies and leave
  // the extra cycles to retiming.
  assign mul_a     = (state == S_IDLE) ? bus.in1 : a_q;
  assign mul_b     = (state == S_IDLE) ? bus.in2 : b_q;
  assign mul_s     = (state == S_IDLE) ? bus.op_signed : sgn_q;
  assign mul_a_ext = {{XLEN{mul_s & mul_a[XLEN-1]}}, mul_a};
  assign mul_b_ext = {{XLEN{mul_s & mul_b[XLEN-1]}}, mul_b};
  assign mul_y     = mul_a_ext * mul_b_ext;

  // Restoring step on magnitudes; the dividend shifts out of div_q as quotient bits shift in.
  assign div_sh   = {div_r, div_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, div_b};
  assign q_fix    = (div_b == '0) ? '1 : ((a_neg ^ b_neg) ? (~div_q + XLEN'(1)) : div_q);
  assign r_fix    = a_neg ? (~div_r + XLEN'(1)) : div_r;
`endif

  always_comb begin
    acc_res = '0;
    if (!legal) begin
      acc_res = '0;
`ifdef ALU_MULDIV_EN
    end else if (is_mul) begin
      acc_res = mul_y;
`endif
    end else begin
      acc_res = {{XLEN{1'b0}}, alu_y};
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_DONE;
`ifdef ALU_MULDIV_EN
          if (legal && is_mul && MUL_LAT > 1) state_d = S_MUL;
          if (legal && is_divrem)             state_d = S_DIV;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      S_MUL:   if (cnt == MUL_LAST) state_d = S_DONE;
      S_DIV:   if (cnt == DIV_LAST) state_d = S_DONE;
`endif
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
  end

  assign bus.result = result_q;
  assign bus.err    = err_q;

  // result/err load only on the transition into DONE, so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept && state_d == S_DONE) begin
        result_q <= acc_res;
        err_q    <= !legal;
      end
`ifdef ALU_MULDIV_EN
      if (state == S_MUL && state_d == S_DONE) begin
        result_q <= mul_y;
        err_q    <= 1'b0;
      end
      if (state == S_DIV && state_d == S_DONE) begin
        result_q <= {{XLEN{1'b0}}, (rem_q ? r_fix : q_fix)};
        err_q    <= 1'b0;
      end
`endif
    end
  end

`ifdef ALU_MULDIV_EN
  // NOTE: datapath registers carry no reset; each is loaded on accept before anything reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= bus.in1;
      b_q   <= bus.in2;
      sgn_q <= bus.op_signed;
      rem_q <= bus.op[OP_REM];
      a_neg <= bus.op_signed & bus.in1[XLEN-1];
      b_neg <= bus.op_signed & bus.in2[XLEN-1];
      div_q <= mag(bus.in1, bus.op_signed);
      div_b <= mag(bus.in2, bus.op_signed);
      div_r <= '0;
      cnt   <= '0;
    end else if (state == S_MUL) begin
      cnt <= cnt + CNTW'(1);
    end else if (state == S_DIV) begin
      cnt <= cnt + CNTW'(1);
      if (cnt != DIV_LAST) begin
        if (!div_diff[XLEN]) begin
          div_r <= div_diff[XLEN-1:0];
          div_q <= {div_q[XLEN-2:0], 1'b1};
        end else begin
          div_r <= div_sh[XLEN-1:0];
          div_q <= {div_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (XLEN=32, MUL_LAT=2); mul/div vectors apply when ALU_MULDIV_EN is defined.
module tb_alu_mc;
  localparam int XLEN     = 32;
  localparam int MUL_LAT  = 2;
  localparam int DIV_LAT  = XLEN + 2;
  localparam int MAX_WAIT = 200;

  localparam logic [15:0] OP_ADD  = 16'h0001;
  localparam logic [15:0] OP_SUB  = 16'h0002;
  localparam logic [15:0] OP_XOR  = 16'h0004;
  localparam logic [15:0] OP_OR   = 16'h0008;
  localparam logic [15:0] OP_AND  = 16'h0010;
  localparam logic [15:0] OP_SLL  = 16'h0020;
  localparam logic [15:0] OP_SRL  = 16'h0040;
  localparam logic [15:0] OP_SRA  = 16'h0080;
  localparam logic [15:0] OP_SLT  = 16'h0100;
  localparam logic [15:0] OP_SLTU = 16'h0200;
  localparam logic [15:0] OP_MUL  = 16'h0400;
  localparam logic [15:0] OP_DIV  = 16'h0800;
  localparam logic [15:0] OP_REM  = 16'h1000;
  localparam logic [15:0] OP_SWAP = 16'h2000;
  localparam logic [15:0] OP_MAX  = 16'h4000;
  localparam logic [15:0] OP_MIN  = 16'h8000;

  typedef struct packed {
    logic [15:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    logic        exp_err;
    logic [7:0]  lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  alu_mc_if #(.XLEN(XLEN)) bus ();
  alu_mc #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive one request and return once it has been accepted; inputs are scrambled afterwards.
  task automatic send(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sgn, output time t_acc);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    bus.in1 = a; bus.in2 = b; bus.op = op; bus.op_signed = sgn; bus.in_valid = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1;
    bus.in_valid  = 1'b0;
    bus.in1       = $urandom;
    bus.in2       = $urandom;
    bus.op        = 16'(1 << $urandom_range(15, 0));
    bus.op_signed = ~sgn;
  endtask

  // Wait for out_valid (bounded), sample, then complete the handshake.
  task automatic collect(output logic [63:0] res, output logic err, output int lat,
                         output logic rdy_done);
    lat = 0;
    while (lat < MAX_WAIT) begin
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    res = bus.result; err = bus.err; rdy_done = bus.in_ready;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic issue(input vec_t v, output logic [63:0] res, output logic err,
                       output int lat, output logic rdy_done);
    time t;
    send(v.op, v.a, v.b, v.sgn, t);
    collect(res, err, lat, rdy_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in1 = '0; bus.in2 = '0; bus.op = '0; bus.op_signed = 1'b0;
    #12;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.result !== 64'h0) begin fails++; $display("FAIL reset_result: got %h want 0", bus.result); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v [5] = '{
      '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0,         1'b0, 8'd1},
      '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 64'hFFFF_FFFF, 1'b0, 8'd1},
      '{OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 64'h5A5A_A5A5, 1'b0, 8'd1},
      '{OP_OR,  32'h0000_F0F0, 32'h0F0F_0000, 1'b0, 64'h0F0F_F0F0, 1'b0, 8'd1},
      '{OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 64'h0F00_0F00, 1'b0, 8'd1}
    };
    logic [63:0] res; logic err; int lat; logic rdy;
    foreach (v[i]) begin
      issue(v[i], res, err, lat, rdy);
      tests++;
      if (res !== v[i].exp || err !== v[i].exp_err || lat != int'(v[i].lat)) begin
        fails++;
        $display("FAIL arith[%0d] op=%h: got result=%h err=%b lat=%0d, want result=%h err=%b lat=%0d",
                 i, v[i].op, res, err, lat, v[i].exp, v[i].exp_err, v[i].lat);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v [5] = '{
      '{OP_SLL, 32'h0000_0001, 32'h0000_0021, 1'b0, 64'h0000_0002, 1'b0, 8'd1},
      '{OP_SLL, 32'hFFFF_FFFF, 32'h0000_001F, 1'b0, 64'h8000_0000, 1'b0, 8'd1},
      '{OP_SRL, 32'h8000_0000, 32'h0000_0004, 1'b0, 64'h0800_0000, 1'b0, 8'd1},
      '{OP_SRA, 32'h8000_0000, 32'h0000_0004, 1'b0, 64'hF800_0000, 1'b0, 8'd1},
      '{OP_SRA, 32'h4000_0000, 32'hFFFF_FFE4, 1'b0, 64'h0400_0000, 1'b0, 8'd1}
    };
    logic [63:0] res; logic err; int lat; logic rdy;
    foreach (v[i]) begin
      issue(v[i], res, err, lat, rdy);
      tests++;
      if (res !== v[i].exp || err !== v[i].exp_err || lat != int'(v[i].lat)) begin
        fails++;
        $display("FAIL shift[%0d] op=%h: got result=%h err=%b lat=%0d, want result=%h err=%b lat=%0d",
                 i, v[i].op, res, err, lat, v[i].exp, v[i].exp_err, v[i].lat);
      end
    end
  endtask

  task automatic test_compare();
    vec_t v [8] = '{
      '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h1,         1'b0, 8'd1},
      '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0,         1'b0, 8'd1},
      '{OP_SLT,  32'h0000_0005, 32'h0000_0005, 1'b0, 64'h0,         1'b0, 8'd1},
      '{OP_MAX,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'h1,         1'b0, 8'd1},
      '{OP_MAX,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'hFFFF_FFFF, 1'b0, 8'd1},
      '{OP_MIN,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF, 1'b0, 8'd1},
      '{OP_MIN,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h1,         1'b0, 8'd1},
      '{OP_SWAP, 32'h0000_1234, 32'h0000_ABCD, 1'b0, 64'hABCD,      1'b0, 8'd1}
    };
    logic [63:0] res; logic err; int lat; logic rdy;
    foreach (v[i]) begin
      issue(v[i], res, err, lat, rdy);
      tests++;
      if (res !== v[i].exp || err !== v[i].exp_err || lat != int'(v[i].lat)) begin
        fails++;
        $display("FAIL compare[%0d] op=%h: got result=%h err=%b lat=%0d, want result=%h err=%b lat=%0d",
                 i, v[i].op, res, err, lat, v[i].exp, v[i].exp_err, v[i].lat);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v [3] = '{
      '{16'h0003, 32'h1234_5678, 32'h0000_0001, 1'b0, 64'h0, 1'b1, 8'd1},
      '{16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0, 1'b1, 8'd1},
      '{16'h8001, 32'h0000_0007, 32'h0000_0003, 1'b1, 64'h0, 1'b1, 8'd1}
    };
    logic [63:0] res; logic err; int lat; logic rdy;
    foreach (v[i]) begin
      issue(v[i], res, err, lat, rdy);
      tests++;
      if (res !== v[i].exp || err !== v[i].exp_err || lat != int'(v[i].lat)) begin
        fails++;
        $display("FAIL illegal[%0d] op=%h: got result=%h err=%b lat=%0d, want result=%h err=%b lat=%0d",
                 i, v[i].op, res, err, lat, v[i].exp, v[i].exp_err, v[i].lat);
      end
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv();
    vec_t v [13] = '{
      '{OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 8'(MUL_LAT)},
      '{OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE, 1'b0, 8'(MUL_LAT)},
      '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0, 8'(MUL_LAT)},
      '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 64'hFFFF_FFFD, 1'b0, 8'(DIV_LAT)},
      '{OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF, 1'b0, 8'(DIV_LAT)},
      '{OP_DIV, 32'h0000_0005, 32'h0000_0000, 1'b0, 64'hFFFF_FFFF, 1'b0, 8'(DIV_LAT)},
      '{OP_REM, 32'h0000_0005, 32'h0000_0000, 1'b0, 64'h0000_0005, 1'b0, 8'(DIV_LAT)},
      '{OP_DIV, 32'h0000_0005, 32'h0000_0000, 1'b1, 64'hFFFF_FFFF, 1'b0, 8'(DIV_LAT)},
      '{OP_REM, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 64'hFFFF_FFFB, 1'b0, 8'(DIV_LAT)},
      '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h8000_0000, 1'b0, 8'(DIV_LAT)},
      '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0,         1'b0, 8'(DIV_LAT)},
      '{OP_DIV, 32'h0000_0064, 32'h0000_0007, 1'b0, 64'h0000_000E, 1'b0, 8'(DIV_LAT)},
      '{OP_REM, 32'h0000_0064, 32'h0000_0007, 1'b0, 64'h0000_0002, 1'b0, 8'(DIV_LAT)}
    };
    logic [63:0] res; logic err; int lat; logic rdy;
    foreach (v[i]) begin
      issue(v[i], res, err, lat, rdy);
      tests++;
      if (res !== v[i].exp || err !== v[i].exp_err || lat != int'(v[i].lat)) begin
        fails++;
        $display("FAIL muldiv[%0d] op=%h: got result=%h err=%b lat=%0d, want result=%h err=%b lat=%0d",
                 i, v[i].op, res, err, lat, v[i].exp, v[i].exp_err, v[i].lat);
      end
    end
  endtask
`else
  task automatic test_muldiv();
    vec_t v [3] = '{
      '{OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'h0, 1'b1, 8'd1},
      '{OP_DIV, 32'h0000_0064, 32'h0000_0007, 1'b0, 64'h0, 1'b1, 8'd1},
      '{OP_REM, 32'h0000_0064, 32'h0000_0007, 1'b0, 64'h0, 1'b1, 8'd1}
    };
    logic [63:0] res; logic err; int lat; logic rdy;
    foreach (v[i]) begin
      issue(v[i], res, err, lat, rdy);
      tests++;
      if (res !== v[i].exp || err !== v[i].exp_err || lat != int'(v[i].lat)) begin
        fails++;
        $display("FAIL muldiv_off[%0d] op=%h: got result=%h err=%b lat=%0d, want result=%h err=%b lat=%0d",
                 i, v[i].op, res, err, lat, v[i].exp, v[i].exp_err, v[i].lat);
      end
    end
  endtask
`endif

  task automatic test_backpressure();
    time t; logic [63:0] res; logic err; int lat; logic rdy;
    send(OP_ADD, 32'h0000_0003, 32'h0000_0004, 1'b0, t);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 64'h7 || bus.err !== 1'b0) begin
        fails++;
        $display("FAIL backpressure cycle %0d: got out_valid=%b in_ready=%b result=%h err=%b, want 1 0 7 0",
                 c, bus.out_valid, bus.in_ready, bus.result, bus.err);
      end
    end
    collect(res, err, lat, rdy);
    tests++;
    if (res !== 64'h7 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: got result=%h out_valid=%b in_ready=%b, want 7 0 1",
               res, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    time t0, t1; logic [63:0] res; logic err; int lat; logic rdy;
    send(OP_SUB, 32'h0000_0010, 32'h0000_0003, 1'b0, t0);
    collect(res, err, lat, rdy);
    tests++;
    if (res !== 64'hD || rdy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got result=%h in_ready_in_done=%b, want d 0", res, rdy);
    end
    send(OP_SWAP, 32'h1111_1111, 32'h2222_2222, 1'b0, t1);
    tests++;
    if (t1 - t0 != 20) begin
      fails++;
      $display("FAIL b2b_throughput: got %0t between accepts, want 20", t1 - t0);
    end
    collect(res, err, lat, rdy);
    tests++;
    if (res !== 64'h2222_2222 || lat != 1) begin
      fails++;
      $display("FAIL b2b_second: got result=%h lat=%0d, want 22222222 1", res, lat);
    end
  endtask

  // Reset while an op is in flight (mid-divide when built, otherwise parked in DONE).
  task automatic test_reset_midop();
    time t; int seen = 0;
`ifdef ALU_MULDIV_EN
    send(OP_DIV, 32'h0000_0064, 32'h0000_0007, 1'b0, t);
    repeat (5) @(negedge clk);
`else
    send(OP_ADD, 32'h0000_0064, 32'h0000_0007, 1'b0, t);
    @(negedge clk);
`endif
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_midop: got out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < DIV_LAT + 4; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    bus.out_ready = 1'b0;
    tests++;
    if (seen != 0 || bus.result !== 64'h0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_stale: got out_valid_cycles=%0d result=%h in_ready=%b, want 0 0 1",
               seen, bus.result, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_compare();
    test_illegal();
    test_muldiv();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_arith();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
